// File: rtl/door_sched_pkg.sv
// Shared types and constants for the door event scheduler.
// Field offsets are in units of WIDTH within one door's 4-field slice.
package door_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StFault
  } door_state_e;

  localparam logic [1:0] FaultNone  = 2'b00;
  localparam logic [1:0] FaultUnder = 2'b01;
  localparam logic [1:0] FaultOver  = 2'b10;
  localparam logic [1:0] FaultInv   = 2'b11;

  localparam int unsigned NumFields = 4;
  localparam int unsigned FieldAIn  = 3;
  localparam int unsigned FieldAOut = 2;
  localparam int unsigned FieldBIn  = 1;
  localparam int unsigned FieldBOut = 0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/door_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward
// from ptr with wrap-around. Purely combinational.
module door_rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/door_event_scheduler.sv
// Round-robin scheduler applying per-door occupancy deltas to two counters
// with invariant checking. Define DOOR_SCHED_STICKY_FAULT_EN for a sticky fault.
module door_event_scheduler
  import door_sched_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NDOORS = 3,
  localparam int unsigned IW    = idx_width(NDOORS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NDOORS-1:0]              req_valid,
  input  logic [NumFields*WIDTH*NDOORS-1:0] req_delta,
  output logic [NDOORS-1:0]              req_ready,
  input  logic                           fault_clr,
  output logic [WIDTH-1:0]               cnt_a,
  output logic [WIDTH-1:0]               cnt_b,
  output logic                           commit_valid,
  output logic [IW-1:0]                  commit_door,
  output logic                           fault,
  output logic [1:0]                     fault_code
);

  door_state_e state_q, state_d;

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_in_q, a_in_d, a_out_q, a_out_d;
  logic [WIDTH-1:0] b_in_q, b_in_d, b_out_q, b_out_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             commit_valid_q, commit_valid_d;
  logic [IW-1:0]    commit_door_q, commit_door_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic [NDOORS-1:0]          grant;
  logic [IW-1:0]              grant_idx;
  logic [NumFields*WIDTH-1:0] door_delta;

  logic signed [WIDTH+1:0] next_a, next_b;
  logic                    underflow, overflow, inv_viol;

  door_rr_arbiter #(
    .N  (NDOORS),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .index (grant_idx)
  );

  assign door_delta = req_delta[NumFields*WIDTH*grant_idx +: NumFields*WIDTH];

  // Gate with rst_n so no grant is offered while reset is held.
  assign req_ready = (state_q == StIdle && rst_n) ? grant : '0;

  // Two guard bits: one for the carry above 2^WIDTH-1, one for the sign.
  assign next_a = $signed({2'b00, cnt_a_q}) + $signed({2'b00, a_in_q})
                - $signed({2'b00, a_out_q});
  assign next_b = $signed({2'b00, cnt_b_q}) + $signed({2'b00, b_in_q})
                - $signed({2'b00, b_out_q});

  assign underflow = next_a[WIDTH+1] | next_b[WIDTH+1];
  assign overflow  = next_a[WIDTH] | next_b[WIDTH];
  assign inv_viol  = next_b > next_a;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    a_in_d         = a_in_q;
    a_out_d        = a_out_q;
    b_in_d         = b_in_q;
    b_out_d        = b_out_q;
    cnt_a_d        = cnt_a_q;
    cnt_b_d        = cnt_b_q;
    commit_valid_d = 1'b0;
    commit_door_d  = commit_door_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          a_in_d        = door_delta[FieldAIn*WIDTH +: WIDTH];
          a_out_d       = door_delta[FieldAOut*WIDTH +: WIDTH];
          b_in_d        = door_delta[FieldBIn*WIDTH +: WIDTH];
          b_out_d       = door_delta[FieldBOut*WIDTH +: WIDTH];
          commit_door_d = grant_idx;
          rr_ptr_d      = (grant_idx == IW'(NDOORS - 1)) ? '0 : grant_idx + 1'b1;
          state_d       = StApply;
        end
      end
      StApply: begin
        if (underflow) begin
          fault_d      = 1'b1;
          fault_code_d = FaultUnder;
          state_d      = StFault;
        end else if (overflow) begin
          fault_d      = 1'b1;
          fault_code_d = FaultOver;
          state_d      = StFault;
        end else if (inv_viol) begin
          fault_d      = 1'b1;
          fault_code_d = FaultInv;
          state_d      = StFault;
        end else begin
          cnt_a_d        = next_a[WIDTH-1:0];
          cnt_b_d        = next_b[WIDTH-1:0];
          commit_valid_d = 1'b1;
          state_d        = StIdle;
        end
      end
      StFault: begin
`ifdef DOOR_SCHED_STICKY_FAULT_EN
        if (fault_clr) begin
          fault_d      = 1'b0;
          fault_code_d = FaultNone;
          state_d      = StIdle;
        end
`else
        fault_d      = 1'b0;
        fault_code_d = FaultNone;
        state_d      = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

`ifndef DOOR_SCHED_STICKY_FAULT_EN
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      a_in_q         <= '0;
      a_out_q        <= '0;
      b_in_q         <= '0;
      b_out_q        <= '0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_door_q  <= '0;
      fault_q        <= 1'b0;
      fault_code_q   <= FaultNone;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      a_in_q         <= a_in_d;
      a_out_q        <= a_out_d;
      b_in_q         <= b_in_d;
      b_out_q        <= b_out_d;
      cnt_a_q        <= cnt_a_d;
      cnt_b_q        <= cnt_b_d;
      commit_valid_q <= commit_valid_d;
      commit_door_q  <= commit_door_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
    end
  end

  assign cnt_a        = cnt_a_q;
  assign cnt_b        = cnt_b_q;
  assign commit_valid = commit_valid_q;
  assign commit_door  = commit_door_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule
